flash_cmd_sequencer: RTL and testbench
======================================

// Module: flash_cmd_sequencer
// PURPOSE
//  Sequences the flash Address block and external flash pins for read, byte-program, sector-erase and chip-erase.
//  Drives the one-hot address selects (SelAddr/Sel5555/SelAAAA/SelHOLD/SelXXXX), the command byte and CE_n/OE_n/WE_n.
//  Sits between the I2C slave front end (issues Start/Op) and the Address/data path. Timing comes from cycle counters, not status polling.
// PARAMETERS
//  WE_PULSE  2         SCL cycles WE_n held low per bus write (1..15)
//  RD_CYCLES 3         SCL cycles CE_n/OE_n held low for a read (1..15)
//  T_BP      20        wait cycles after byte-program sequence (24-bit)
//  T_SE      1000      wait cycles after sector-erase sequence (24-bit)
//  T_CE      4000      wait cycles after chip-erase sequence (24-bit)
// PORTS
//  SCL        in   1  clock; all logic on rising edge
//  Reset_n    in   1  synchronous active-low reset
//  Start      in   1  request strobe, sampled only in IDLE
//  Op         in   2  00 read, 01 byte program, 10 sector erase, 11 chip erase
//  AutoIncr   in   1  pulse IncrAddr at completion of read/program
//  Busy       out  1  high from the cycle after Start is accepted until the DONE cycle, inclusive
//  Done       out  1  one-cycle completion pulse
//  SelAddr    out  1  Address mux: user address
//  Sel5555    out  1  Address mux: 0x5555
//  SelAAAA    out  1  Address mux: 0xAAAA (2nd unlock)
//  SelHOLD    out  1  Address mux: hold last value
//  SelXXXX    out  1  Address mux: don't-care / idle
//  IncrAddr   out  1  one-cycle address increment pulse
//  CmdByte    out  8  command data byte driven onto the flash data bus
//  DrvUser    out  1  1 = data bus takes user data (shift register), not CmdByte
//  LatchData  out  1  one-cycle strobe to capture flash read data
//  CE_n       out  1  flash chip enable
//  OE_n       out  1  flash output enable
//  WE_n       out  1  flash write enable
// BEHAVIOUR
//  Reset: IDLE. SelXXXX=1, other selects 0. CE_n=OE_n=WE_n=1. Busy, Done, IncrAddr, LatchData, DrvUser = 0. CmdByte=0x00.
//  Address selects are one-hot in every cycle.
//  States: IDLE, SETUP, WE_LOW, HOLD, WAIT, READ, DONE. Step counter (0..5) indexes the bus-cycle table.
//  IDLE: Start=1 latches Op, clears step and enters SETUP (read: READ). Start in any other state is ignored.
//  Bus write = 1 SETUP cycle (CE_n=0, WE_n=1, addr/data valid), then WE_PULSE WE_LOW cycles, then 1 HOLD cycle (WE_n=1).
//    Addr/data stay stable across all three phases.
//  After HOLD, step increments. Last step goes to WAIT; otherwise returns to SETUP.
//  Program table: 5555/AA, AAAA/55, 5555/A0, Addr/user.
//  Sector erase table: 5555/AA, AAAA/55, 5555/80, 5555/AA, AAAA/55, Addr/30.
//  Chip erase table: as sector erase, but last step is 5555/10.
//  WAIT: SelHOLD=1, CE_n=1. Runs T_BP/T_SE/T_CE cycles (a value of 0 is treated as 1), then DONE.
//  READ: SelAddr=1, CE_n=OE_n=0 for RD_CYCLES cycles. LatchData=1 on the last cycle, then DONE.
//  DONE: one cycle. Done=1, IncrAddr=AutoIncr for Op 00/01 (0 for erases), SelXXXX=1. Next state IDLE.
//  Latency from the Start-accepting edge to Done high:
//    read RD_CYCLES+1; program 4*(2+WE_PULSE)+T_BP+1; erase 6*(2+WE_PULSE)+T_xx+1.
//  Reset_n low mid-operation: reset values at the next edge (WE_n high, no Done). Start in that cycle is ignored.
//  Start held high through completion: a new request is accepted in the first IDLE cycle after DONE.
// TESTING
//  1. Reset, Op=01, Start 1 cycle (defaults) -> 4 WE_n lows of 2 cycles each.
//     Addr/data 5555/AA, AAAA/55, 5555/A0, SelAddr+DrvUser. Done at cycle 37. IncrAddr=AutoIncr.
//  2. Op=10 sector erase -> 6 WE_n pulses, last with SelAddr/CmdByte=0x30, SelHOLD for 1000 cycles, Done at cycle 1025, IncrAddr=0.
//  3. Op=11 chip erase -> last bus cycle Sel5555/CmdByte=0x10. Done at cycle 4025.
//  4. Op=00 read -> CE_n=OE_n=0 for cycles 1-3, LatchData at cycle 3, Done at cycle 4, WE_n never low.
//  5. Start pulses during Busy -> ignored. Only one Done per accepted request. Selects one-hot every cycle (assertion).
//  6. Reset_n low during WE_LOW of program step 2 -> next edge WE_n=1, SelXXXX=1, Busy=0. Fresh Start completes normally.

Source files
------------

// File: rtl/flash_cmd_sequencer.sv
// rtl/flash_cmd_sequencer.sv - flash command sequencer for read, byte-program, sector- and chip-erase
module flash_cmd_sequencer #(
    parameter int          WE_PULSE  = 2,
    parameter int          RD_CYCLES = 3,
    parameter logic [23:0] T_BP      = 24'd20,
    parameter logic [23:0] T_SE      = 24'd1000,
    parameter logic [23:0] T_CE      = 24'd4000
) (
    input  logic       SCL,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic [1:0] Op,
    input  logic       AutoIncr,
    output logic       Busy,
    output logic       Done,
    output logic       SelAddr,
    output logic       Sel5555,
    output logic       SelAAAA,
    output logic       SelHOLD,
    output logic       SelXXXX,
    output logic       IncrAddr,
    output logic [7:0] CmdByte,
    output logic       DrvUser,
    output logic       LatchData,
    output logic       CE_n,
    output logic       OE_n,
    output logic       WE_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WE_LOW, S_HOLD, S_WAIT, S_READ, S_DONE
    } state_t;

    typedef enum logic [1:0] {T_5555, T_AAAA, T_ADDR} tsel_t;

    localparam logic [1:0]  OP_READ = 2'b00;
    localparam logic [1:0]  OP_PROG = 2'b01;
    localparam logic [1:0]  OP_SE   = 2'b10;
    localparam logic [23:0] WE_LAST = 24'(WE_PULSE - 1);
    localparam logic [23:0] RD_LAST = 24'(RD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  step_q, step_d;
    logic [23:0] cnt_q, cnt_d;

    logic [23:0] wait_len, wait_last;
    logic        last_step;
    tsel_t       tbl_sel;
    logic [7:0]  tbl_byte;
    logic        tbl_user;

    always_ff @(posedge SCL) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            step_q  <= 3'd0;
            cnt_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // A zero wait length still spends one cycle in WAIT.
    always_comb begin
        case (op_q)
            OP_PROG: wait_len = T_BP;
            OP_SE:   wait_len = T_SE;
            default: wait_len = T_CE;
        endcase
        wait_last = (wait_len == 24'd0) ? 24'd0 : wait_len - 24'd1;
        last_step = (op_q == OP_PROG) ? (step_q == 3'd3) : (step_q == 3'd5);
    end

    always_comb begin
        tbl_sel  = T_5555;
        tbl_byte = 8'h00;
        tbl_user = 1'b0;
        case (step_q)
            3'd0: tbl_byte = 8'hAA;
            3'd1: begin tbl_sel = T_AAAA; tbl_byte = 8'h55; end
            3'd2: tbl_byte = (op_q == OP_PROG) ? 8'hA0 : 8'h80;
            3'd3: begin
                if (op_q == OP_PROG) begin
                    tbl_sel  = T_ADDR;
                    tbl_user = 1'b1;
                end else begin
                    tbl_byte = 8'hAA;
                end
            end
            3'd4: begin tbl_sel = T_AAAA; tbl_byte = 8'h55; end
            3'd5: begin
                if (op_q == OP_SE) begin
                    tbl_sel  = T_ADDR;
                    tbl_byte = 8'h30;
                end else begin
                    tbl_byte = 8'h10;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        Busy      = (state_q != S_IDLE);
        Done      = 1'b0;
        SelAddr   = 1'b0;
        Sel5555   = 1'b0;
        SelAAAA   = 1'b0;
        SelHOLD   = 1'b0;
        SelXXXX   = 1'b0;
        IncrAddr  = 1'b0;
        CmdByte   = 8'h00;
        DrvUser   = 1'b0;
        LatchData = 1'b0;
        CE_n      = 1'b1;
        OE_n      = 1'b1;
        WE_n      = 1'b1;

        case (state_q)
            S_IDLE: begin
                SelXXXX = 1'b1;
                if (Start) begin
                    op_d    = Op;
                    step_d  = 3'd0;
                    cnt_d   = 24'd0;
                    state_d = (Op == OP_READ) ? S_READ : S_SETUP;
                end
            end
            S_SETUP, S_WE_LOW, S_HOLD: begin
                SelAddr = (tbl_sel == T_ADDR);
                Sel5555 = (tbl_sel == T_5555);
                SelAAAA = (tbl_sel == T_AAAA);
                CmdByte = tbl_byte;
                DrvUser = tbl_user;
                CE_n    = 1'b0;
                if (state_q == S_SETUP) begin
                    cnt_d   = 24'd0;
                    state_d = S_WE_LOW;
                end else if (state_q == S_WE_LOW) begin
                    WE_n = 1'b0;
                    if (cnt_q == WE_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end else if (last_step) begin
                    cnt_d   = 24'd0;
                    state_d = S_WAIT;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = S_SETUP;
                end
            end
            S_WAIT: begin
                SelHOLD = 1'b1;
                if (cnt_q == wait_last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_READ: begin
                SelAddr = 1'b1;
                CE_n    = 1'b0;
                OE_n    = 1'b0;
                if (cnt_q == RD_LAST) begin
                    LatchData = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_DONE: begin
                Done     = 1'b1;
                SelXXXX  = 1'b1;
                IncrAddr = AutoIncr && (op_q == OP_READ || op_q == OP_PROG);
                state_d  = S_IDLE;
            end
            default: begin
                SelXXXX = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb/tb_flash_cmd_sequencer.sv - directed self-checking bench for flash_cmd_sequencer
module tb_flash_cmd_sequencer;

    logic       SCL = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic [1:0] Op;
    logic       AutoIncr;
    logic       Busy, Done, SelAddr, Sel5555, SelAAAA, SelHOLD, SelXXXX;
    logic       IncrAddr, DrvUser, LatchData, CE_n, OE_n, WE_n;
    logic [7:0] CmdByte;

    int total = 0;
    int bad   = 0;

    flash_cmd_sequencer dut (
        .SCL(SCL), .Reset_n(Reset_n), .Start(Start), .Op(Op), .AutoIncr(AutoIncr),
        .Busy(Busy), .Done(Done), .SelAddr(SelAddr), .Sel5555(Sel5555),
        .SelAAAA(SelAAAA), .SelHOLD(SelHOLD), .SelXXXX(SelXXXX),
        .IncrAddr(IncrAddr), .CmdByte(CmdByte), .DrvUser(DrvUser),
        .LatchData(LatchData), .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n)
    );

    always #5 SCL = ~SCL;

    localparam logic [4:0] P_ADDR = 5'b10000;
    localparam logic [4:0] P_5555 = 5'b01000;
    localparam logic [4:0] P_AAAA = 5'b00100;
    localparam logic [4:0] P_HOLD = 5'b00010;
    localparam logic [4:0] P_XXXX = 5'b00001;

    logic [4:0] sel_v;
    assign sel_v = {SelAddr, Sel5555, SelAAAA, SelHOLD, SelXXXX};

    // Statistics gathered over one operation
    int         done_cyc, done_cnt, we_pulses, we_low, oe_low, oe_first, latch_cyc;
    int         hold_cyc, onehot_err, busy_err;
    logic       incr_seen;
    logic [4:0] p_sel  [6];
    logic [7:0] p_byte [6];
    logic       p_user [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic ai, input int budget, input bit noise);
        logic prev_we;
        bit   seen;
        @(negedge SCL);
        Op = op; AutoIncr = ai; Start = 1'b1;
        @(posedge SCL);
        #1 Start = 1'b0;
        done_cyc = 0; done_cnt = 0; we_pulses = 0; we_low = 0; oe_low = 0;
        oe_first = 0; latch_cyc = 0; hold_cyc = 0; onehot_err = 0; busy_err = 0;
        incr_seen = 1'b0; prev_we = 1'b1; seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            p_sel[i] = 5'b0; p_byte[i] = 8'h0; p_user[i] = 1'b0;
        end
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge SCL);
            if (!$onehot(sel_v)) onehot_err++;
            if (Busy !== !seen) busy_err++;
            if (!WE_n) begin
                we_low++;
                if (prev_we) begin
                    if (we_pulses < 6) begin
                        p_sel[we_pulses]  = sel_v;
                        p_byte[we_pulses] = CmdByte;
                        p_user[we_pulses] = DrvUser;
                    end
                    we_pulses++;
                end
            end
            prev_we = WE_n;
            if (!OE_n) begin
                oe_low++;
                if (oe_first == 0) oe_first = cyc;
            end
            if (LatchData) latch_cyc = cyc;
            if (SelHOLD) hold_cyc++;
            if (Done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc  = cyc;
                    incr_seen = IncrAddr;
                end
                seen = 1'b1;
            end
            Start = noise && !seen && !Done && (cyc % 7 == 3);
        end
        Start = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; AutoIncr = 1'b0;
        repeat (3) @(posedge SCL);
        @(negedge SCL);
        chk("rst_sel", 32'(sel_v), 32'(P_XXXX));
        chk("rst_pins", {CE_n, OE_n, WE_n}, 3'b111);
        chk("rst_flags", {Busy, Done, IncrAddr, LatchData, DrvUser}, 5'b0);
        chk("rst_cmd", 32'(CmdByte), 32'h00);
        Reset_n = 1'b1;

        // Byte program with auto-increment
        run_op(2'b01, 1'b1, 47, 1'b0);
        chk("prog_done_cyc", done_cyc, 37);
        chk("prog_done_cnt", done_cnt, 1);
        chk("prog_we_pulses", we_pulses, 4);
        chk("prog_we_low", we_low, 8);
        chk("prog_w0", {p_sel[0], p_byte[0], p_user[0]}, {P_5555, 8'hAA, 1'b0});
        chk("prog_w1", {p_sel[1], p_byte[1], p_user[1]}, {P_AAAA, 8'h55, 1'b0});
        chk("prog_w2", {p_sel[2], p_byte[2], p_user[2]}, {P_5555, 8'hA0, 1'b0});
        chk("prog_w3_sel_user", {p_sel[3], p_user[3]}, {P_ADDR, 1'b1});
        chk("prog_hold", hold_cyc, 20);
        chk("prog_incr", 32'(incr_seen), 1);
        chk("prog_busy", busy_err, 0);
        chk("prog_onehot", onehot_err, 0);

        // Program without auto-increment
        run_op(2'b01, 1'b0, 40, 1'b0);
        chk("prog_noincr", 32'(incr_seen), 0);

        // Sector erase, with Start pulses while busy
        run_op(2'b10, 1'b1, 1040, 1'b1);
        chk("se_done_cyc", done_cyc, 1025);
        chk("se_done_cnt", done_cnt, 1);
        chk("se_we_pulses", we_pulses, 6);
        chk("se_w2", {p_sel[2], p_byte[2]}, {P_5555, 8'h80});
        chk("se_w3", {p_sel[3], p_byte[3]}, {P_5555, 8'hAA});
        chk("se_w5", {p_sel[5], p_byte[5], p_user[5]}, {P_ADDR, 8'h30, 1'b0});
        chk("se_hold", hold_cyc, 1000);
        chk("se_incr", 32'(incr_seen), 0);
        chk("se_busy", busy_err, 0);
        chk("se_onehot", onehot_err, 0);

        // Chip erase
        run_op(2'b11, 1'b1, 4035, 1'b0);
        chk("ce_done_cyc", done_cyc, 4025);
        chk("ce_we_pulses", we_pulses, 6);
        chk("ce_w4", {p_sel[4], p_byte[4]}, {P_AAAA, 8'h55});
        chk("ce_w5", {p_sel[5], p_byte[5]}, {P_5555, 8'h10});
        chk("ce_incr", 32'(incr_seen), 0);
        chk("ce_onehot", onehot_err, 0);

        // Read
        run_op(2'b00, 1'b1, 10, 1'b1);
        chk("rd_done_cyc", done_cyc, 4);
        chk("rd_done_cnt", done_cnt, 1);
        chk("rd_oe_low", oe_low, 3);
        chk("rd_oe_first", oe_first, 1);
        chk("rd_latch", latch_cyc, 3);
        chk("rd_we_pulses", we_pulses, 0);
        chk("rd_incr", 32'(incr_seen), 1);
        chk("rd_busy", busy_err, 0);

        // Reset during WE_LOW of the second program write (cycles 6..7)
        @(negedge SCL);
        Op = 2'b01; AutoIncr = 1'b0; Start = 1'b1;
        @(posedge SCL);
        #1 Start = 1'b0;
        repeat (6) @(negedge SCL);
        chk("rst_mid_we_low", 32'(WE_n), 0);
        Reset_n = 1'b0; Start = 1'b1;
        @(negedge SCL);
        chk("rst_mid_we", 32'(WE_n), 1);
        chk("rst_mid_sel", 32'(sel_v), 32'(P_XXXX));
        chk("rst_mid_flags", {Busy, Done}, 2'b00);
        Reset_n = 1'b1; Start = 1'b0;
        @(negedge SCL);
        chk("rst_start_ignored", 32'(Busy), 0);
        run_op(2'b01, 1'b1, 40, 1'b0);
        chk("rst_fresh_done", done_cyc, 37);
        chk("rst_fresh_cnt", done_cnt, 1);

        // Start held through completion re-arms in the first IDLE cycle
        @(negedge SCL);
        Op = 2'b00; Start = 1'b1;
        @(posedge SCL);
        repeat (4) @(negedge SCL);
        chk("hold_done", 32'(Done), 1);
        @(negedge SCL);
        chk("hold_idle", 32'(Busy), 0);
        @(negedge SCL);
        Start = 1'b0;
        chk("hold_reaccept", 32'(Busy), 1);
        repeat (6) @(negedge SCL);
        chk("hold_final_idle", 32'(Busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
